// File: rtl/pc_stack_unit.sv
// Program counter with a circular return-address stack.
// State commits once per 8-phase instruction cycle; nibble-serial address out.
module pc_stack_unit #(
    parameter int ADDR_W      = 12,
    parameter int NIB_W       = 4,
    parameter int STACK_DEPTH = 3,
    parameter int PAGE_W      = 8,
    parameter int UPD_CYCLE   = 7,
    localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        cycle,
    input  logic              jump,
    input  logic              jump_short,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [NIB_W-1:0]  pc_nib,
    output logic [LVL_W-1:0]  stack_level,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int A_CYC = ADDR_W / NIB_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              commit;
    logic              do_pop;
    logic              do_push;
    logic [ADDR_W-1:0] pc_inc;
    logic [SP_W-1:0]   sp_inc;
    logic [SP_W-1:0]   sp_dec;
    logic              lvl_full;
    logic              lvl_empty;

    assign commit    = (cycle == 3'(UPD_CYCLE));
    assign do_pop    = commit && pop;
    // Push is dropped when pop is requested in the same instruction.
    assign do_push   = commit && push && !pop;
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign lvl_full  = (lvl_q == LVL_W'(STACK_DEPTH));
    assign lvl_empty = (lvl_q == '0);

    // Circular stack pointer neighbours, wrapping modulo STACK_DEPTH.
    always_comb begin
        sp_inc = sp_q + SP_W'(1);
        sp_dec = sp_q - SP_W'(1);
        if (sp_q == SP_W'(STACK_DEPTH - 1)) begin
            sp_inc = '0;
        end
        if (sp_q == '0) begin
            sp_dec = SP_W'(STACK_DEPTH - 1);
        end
    end

    // Next-state selection: pop > push > jump > jump_short > increment.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        lvl_d = lvl_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (commit) begin
            pc_d = pc_inc;
            if (pop) begin
                pc_d = stack_q[sp_dec];
                sp_d = sp_dec;
                if (lvl_empty) begin
                    unf_d = 1'b1;
                end else begin
                    lvl_d = lvl_q - LVL_W'(1);
                end
            end else if (push) begin
                pc_d = jump_addr;
                sp_d = sp_inc;
                if (lvl_full) begin
                    ovf_d = 1'b1;
                end else begin
                    lvl_d = lvl_q + LVL_W'(1);
                end
            end else if (jump) begin
                pc_d = jump_addr;
            end else if (jump_short) begin
                pc_d = {pc_inc[ADDR_W-1:PAGE_W], jump_addr[PAGE_W-1:0]};
            end
        end
    end

    // PC, pointer, level and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            sp_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            lvl_q <= lvl_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; a full stack overwrites its oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (do_push) begin
            stack_q[sp_q] <= pc_inc;
        end
    end

    // Address nibble for phases A1..An, low nibble first, zero elsewhere.
    always_comb begin
        pc_nib = '0;
        for (int k = 0; k < A_CYC; k++) begin
            if (cycle == 3'(k)) begin
                pc_nib = pc_q[k*NIB_W +: NIB_W];
            end
        end
    end

    assign pc_addr     = pc_q;
    assign stack_level = lvl_q;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;

    logic unused_ok;
    assign unused_ok = do_pop;

endmodule
